// File: rtl/keypad_emulator_if.sv
// rtl/keypad_emulator_if.sv - host request and row/column matrix signals of the keypad emulator
interface keypad_emulator_if #(
    parameter int HOLD_W = 16
);
    logic              start;
    logic [3:0]        key;
    logic [HOLD_W-1:0] hold_cycles;
    logic              bounce_en;
    logic [3:0]        row;
    logic [3:0]        col;
    logic              busy;
    logic              done;

    // master is the host plus row scanner; slave is the emulated keypad
    modport master (
        output start, key, hold_cycles, bounce_en, row,
        input  col, busy, done
    );

    modport slave (
        input  start, key, hold_cycles, bounce_en, row,
        output col, busy, done
    );
endinterface

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 matrix keypad model sequencing press bounce, hold and release bounce
module keypad_emulator #(
    parameter int         BOUNCE_CYCLES = 16,
    parameter int         HOLD_W        = 16,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    keypad_emulator_if.slave kp
);

    localparam int BCNT_W = $clog2(BOUNCE_CYCLES) + 1;
    localparam int CNT_W  = (HOLD_W > BCNT_W) ? HOLD_W : BCNT_W;
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_B,
        S_HOLD,
        S_REL_B,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [CNT_W-1:0]  hold_last;
    logic [7:0]        lfsr;
    logic [7:0]        lfsr_nx;
    logic              contact;
    logic              contact_nx;
    logic              bounce_sel;
    logic              accept;
    logic [3:0]        key_row;
    logic [3:0]        key_col;
    logic [HOLD_W-1:0] hold_q;
    logic              bounce_q;

    // Returns {row one-hot, col one-hot}; col bit3 is the leftmost key of a row
    function automatic logic [7:0] key_decode(input logic [3:0] k);
        logic [7:0] rc;
        case (k)
            4'h1:    rc = {4'b0001, 4'b0001};
            4'h2:    rc = {4'b0001, 4'b0010};
            4'h3:    rc = {4'b0001, 4'b0100};
            4'hA:    rc = {4'b0001, 4'b1000};
            4'h4:    rc = {4'b0010, 4'b0001};
            4'h5:    rc = {4'b0010, 4'b0010};
            4'h6:    rc = {4'b0010, 4'b0100};
            4'hB:    rc = {4'b0010, 4'b1000};
            4'h7:    rc = {4'b0100, 4'b0001};
            4'h8:    rc = {4'b0100, 4'b0010};
            4'h9:    rc = {4'b0100, 4'b0100};
            4'hC:    rc = {4'b0100, 4'b1000};
            4'hE:    rc = {4'b1000, 4'b0001};
            4'h0:    rc = {4'b1000, 4'b0010};
            4'hF:    rc = {4'b1000, 4'b0100};
            default: rc = {4'b1000, 4'b1000};
        endcase
        return rc;
    endfunction

    assign accept  = (state == S_IDLE) && kp.start;
    assign lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // The press being accepted this cycle has not latched bounce_en yet
    assign bounce_sel = (state == S_IDLE) ? kp.bounce_en : bounce_q;

    // A zero hold request still gives one stable-contact cycle
    always_comb begin
        hold_last = '0;
        if (hold_q != '0) begin
            hold_last = CNT_W'(hold_q) - CNT_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (kp.start) begin
                    state_nx = S_PRESS_B;
                    cnt_nx   = '0;
                end
            end
            S_PRESS_B: begin
                if (cnt == BOUNCE_LAST) begin
                    state_nx = S_HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt == hold_last) begin
                    state_nx = S_REL_B;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_REL_B: begin
                if (cnt == BOUNCE_LAST) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // contact is registered alongside the state so chatter tracks the live lfsr[0]
    always_comb begin
        contact_nx = 1'b0;
        case (state_nx)
            S_PRESS_B: contact_nx = bounce_sel ? lfsr_nx[0] : 1'b1;
            S_HOLD:    contact_nx = 1'b1;
            S_REL_B:   contact_nx = bounce_sel ? lfsr_nx[0] : 1'b0;
            default:   contact_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            contact <= 1'b0;
            lfsr    <= LFSR_SEED;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            contact <= contact_nx;
            lfsr    <= lfsr_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_row  <= 4'b0000;
            key_col  <= 4'b0000;
            hold_q   <= '0;
            bounce_q <= 1'b0;
        end else if (accept) begin
            {key_row, key_col} <= key_decode(kp.key);
            hold_q             <= kp.hold_cycles;
            bounce_q           <= kp.bounce_en;
        end
    end

    assign kp.col  = (contact && ((kp.row & key_row) != 4'b0000)) ? key_col : 4'b0000;
    assign kp.busy = (state != S_IDLE);
    assign kp.done = (state == S_DONE);

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Behavioural-synthesizable 4x4 matrix keypad model that responds to a row scanner's one-hot row drive with the column pattern of a simulated key press.
- Used on-chip or in benches to exercise the keypad scan/decode/debounce path without a physical keypad.
- A host requests a press of one hex key for a programmed hold time. The block sequences press bounce, stable hold and release bounce, then reports completion.

Parameters:
- BOUNCE_CYCLES, 16, clk cycles spent in each bounce phase (press and release); must be >= 1.
- HOLD_W, 16, width of hold_cycles input and hold counter.
- LFSR_SEED, 8'hA5, non-zero reset value of the bounce LFSR.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low (asserted when 0); forces IDLE immediately.
- start  input  1  one-cycle request to begin a press; sampled only in IDLE.
- key  input  4  hex key to press; latched on accepted start.
- hold_cycles  input  HOLD_W  stable-contact duration in clk cycles; latched on accepted start.
- bounce_en  input  1  1 = pseudo-random contact chatter in bounce phases; 0 = clean edges; latched on accepted start.
- row  input  4  one-hot row drive from scanner: bit0 = row1 ... bit3 = row4.
- col  output  4  column return; 0 = no contact.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse in the DONE state.

Behaviour:
- Reset values: state = IDLE, contact = 0, col = 0, busy = 0, done = 0, counters = 0, lfsr = LFSR_SEED. Reset mid-operation abandons the press with no done pulse.
- Key map, key -> (row bit, col bit), matching the scan decoder. Col bit3 is the leftmost key in each row.
  - Row1: A->bit3, 3->bit2, 2->bit1, 1->bit0.
  - Row2: B->3, 6->2, 5->1, 4->0.
  - Row3: C->3, 9->2, 8->1, 7->0.
  - Row4: D->3, F->2, 0->1, E->0.
  - Encoding is registered at start as key_row[3:0] and key_col[3:0], both one-hot.
- col = (contact && (row & key_row) != 0) ? key_col : 4'b0000.
  - This path is combinational from row, so col follows row in the same cycle.
  - contact is registered.
  - row with multiple bits set drives col if any set bit matches key_row. row = 0 gives col = 0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every clk cycle regardless of state; chatter bit = lfsr[0].
- State machine (registered):
  - IDLE: contact = 0. On start, latch key, hold_cycles and bounce_en, then go to PRESS_B and clear the counter.
  - PRESS_B: contact = bounce_en ? lfsr[0] : 1. Count BOUNCE_CYCLES cycles, then go to HOLD.
  - HOLD: contact = 1. Count max(hold_cycles, 1) cycles, then go to REL_B. hold_cycles = 0 is treated as 1.
  - REL_B: contact = bounce_en ? lfsr[0] : 0. Count BOUNCE_CYCLES cycles, then go to DONE.
  - DONE: contact = 0, done = 1 for one cycle, then go to IDLE.
- Latency: start at edge N gives contact at edge N+1 (PRESS_B entry). With bounce_en = 0, total busy length = 2*BOUNCE_CYCLES + max(hold,1) + 1 cycles.
- start while busy: ignored, not queued. start in the same cycle as DONE: ignored. start is accepted the next cycle in IDLE.
- key, hold_cycles and bounce_en changes after acceptance have no effect on the press in progress.
- Counter width: max(HOLD_W, clog2(BOUNCE_CYCLES)+1). No wrap-around is permitted within a phase.

Test Plan:
- Reset low mid-HOLD with key=5 and row=4'b0010 -> col = 0, busy = 0 immediately (asynchronous). After release: IDLE, no done pulse, lfsr = 8'hA5.
- start with key=5, hold=10, bounce_en=0, row held at 4'b0010 -> col = 0 until edge N+1, then col = 4'b0010 for exactly 16+10 = 26 cycles. done pulses at cycle 16+10+16+1 = 43 after start; busy is high for 43 cycles.
- Sweep all 16 keys with bounce_en=0 while cycling row through 0001/0010/0100/1000 -> col is non-zero only on the key's row, with the mapped bit. Examples: key=F -> col = 4'b0100 on row 1000; key=0 -> col = 4'b0010 on row 1000.
- key=A, hold=0, bounce_en=1 -> HOLD lasts 1 cycle. PRESS_B/REL_B col toggles between 4'b1000 and 0 following lfsr[0], matching a reference LFSR model from seed A5.
- start pulsed again at cycle 5 of a press with key=7 -> ignored: col still shows the original key and only one done pulse occurs. A start 1 cycle after done is accepted.
- key=3 pressed with row = 4'b0000, then row = 4'b1111, then row = 4'b0001 during HOLD -> col = 0, then 4'b0100, then 4'b0100, each in the same cycle as the row change.
